// File: rtl/mux_sched_pkg.sv
// Shared definitions for the round-robin mux scheduler family.
// Contents: default geometry, FSM state type, one-hot to binary helper.
package mux_sched_pkg;

    localparam int unsigned DEF_N_REQ    = 4;
    localparam int unsigned DEF_SEL_W    = 2;
    localparam int unsigned DEF_DATA_W   = 1;
    localparam int unsigned DEF_MAX_HOLD = 8;

    // Helper operates on the widest supported requester count (16).
    localparam int unsigned OH_MAX_W  = 16;
    localparam int unsigned BIN_MAX_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_e;

    // Binary index of a one-hot vector; zero input yields zero.
    function automatic logic [BIN_MAX_W-1:0] onehot_to_bin(input logic [OH_MAX_W-1:0] oh);
        logic [BIN_MAX_W-1:0] bin;
        bin = '0;
        for (int unsigned i = 0; i < OH_MAX_W; i++) begin
            if (oh[i]) begin
                bin = bin | BIN_MAX_W'(i);
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// Requester/scheduler bus for the round-robin mux scheduler.
// master: requester side (drives req, data_in).
// slave : scheduler side (drives grant, sel, busy, data_out, valid_out).
interface mux_rr_scheduler_if
    import mux_sched_pkg::*;
#(
    parameter int unsigned N_REQ  = DEF_N_REQ,
    parameter int unsigned SEL_W  = DEF_SEL_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] data_in;
    logic [N_REQ-1:0]        grant;
    logic [SEL_W-1:0]        sel;
    logic                    busy;
    logic [DATA_W-1:0]       data_out;
    logic                    valid_out;

    modport master (
        output req, data_in,
        input  grant, sel, busy, data_out, valid_out
    );

    modport slave (
        input  req, data_in,
        output grant, sel, busy, data_out, valid_out
    );

endinterface

// File: rtl/mux_rr_scheduler_rr_pick.sv
// rr_pick: combinational rotating priority encoder.
// Ports: req (N request bits), ptr (search start) -> found (any req set),
//        idx (first set bit at or above ptr, wrapping mod N).
module rr_pick #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] cand;

    // N is a power of two, so W-bit addition wraps mod N for free.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = W'(ptr + W'(i));
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: round-robin owner of a shared N:1 select mux.
// Ports: clk, rst_n (async active-low), bus (slave modport): req/data_in in;
//        grant (one-hot), sel, busy, data_out, valid_out out, all registered.
// Build option: HOLD_LIMIT_EN caps a grant at MAX_HOLD cycles while others wait.
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int unsigned N_REQ    = DEF_N_REQ,
    parameter int unsigned SEL_W    = DEF_SEL_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input logic               clk,
    input logic               rst_n,
    mux_rr_scheduler_if.slave bus
);

    localparam bit CFG_OK = (SEL_W == $clog2(N_REQ)) && (N_REQ >= 2) && (N_REQ <= 16)
                            && (MAX_HOLD >= 1);

    if (!CFG_OK) begin : g_cfg_check
        $error("mux_rr_scheduler: inconsistent N_REQ/SEL_W/MAX_HOLD");
    end

    sched_state_e      state_q, state_nxt;
    logic [N_REQ-1:0]  grant_q, grant_nxt;
    logic [SEL_W-1:0]  sel_q, sel_nxt;
    logic [SEL_W-1:0]  ptr_q, ptr_nxt;
    logic              busy_q, busy_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic              valid_q, valid_nxt;

`ifdef HOLD_LIMIT_EN
    localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
`endif

    logic [N_REQ-1:0]  pick_req;
    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;
    logic              take;
    logic [SEL_W-1:0]  lane_sel;
    logic [DATA_W-1:0] lanes [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_lane
        assign lanes[k] = bus.data_in[k*DATA_W +: DATA_W];
    end

    // Forced rotation must skip the current owner, which still requests.
    always_comb begin
        pick_req = bus.req;
`ifdef HOLD_LIMIT_EN
        if ((state_q == GRANT) && bus.req[sel_q]) begin
            pick_req = bus.req & ~grant_q;
        end
`endif
    end

    rr_pick #(
        .N (N_REQ),
        .W (SEL_W)
    ) u_pick (
        .req   (pick_req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign lane_sel = SEL_W'(onehot_to_bin(OH_MAX_W'(grant_q)));

    // Next-state, grant and datapath selection.
    always_comb begin
        state_nxt = state_q;
        grant_nxt = grant_q;
        sel_nxt   = sel_q;
        ptr_nxt   = ptr_q;
        busy_nxt  = busy_q;
        valid_nxt = |grant_q;
        data_nxt  = (|grant_q) ? lanes[lane_sel] : data_q;
        take      = 1'b0;
`ifdef HOLD_LIMIT_EN
        cnt_nxt   = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                take = pick_found;
            end
            GRANT: begin
                if (!bus.req[sel_q]) begin
                    if (pick_found) begin
                        take = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        busy_nxt  = 1'b0;
                    end
                end
`ifdef HOLD_LIMIT_EN
                else if (cnt_q == CNT_LAST) begin
                    // Saturate and keep the owner when nobody else waits.
                    take = pick_found;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                busy_nxt  = 1'b0;
            end
        endcase

        if (take) begin
            state_nxt = GRANT;
            grant_nxt = N_REQ'(1) << pick_idx;
            sel_nxt   = pick_idx;
            ptr_nxt   = SEL_W'(pick_idx + SEL_W'(1));
            busy_nxt  = 1'b1;
`ifdef HOLD_LIMIT_EN
            cnt_nxt   = '0;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef HOLD_LIMIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_nxt;
            grant_q <= grant_nxt;
            sel_q   <= sel_nxt;
            ptr_q   <= ptr_nxt;
            busy_q  <= busy_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
`ifdef HOLD_LIMIT_EN
            cnt_q   <= cnt_nxt;
`endif
        end
    end

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = busy_q;
    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Self-checking bench for mux_rr_scheduler (N_REQ=4, DATA_W=1, MAX_HOLD=8).
// Honours HOLD_LIMIT_EN in its reference model and directed expectations.
module tb_mux_rr_scheduler;

    localparam int MAXH = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mux_rr_scheduler_if #(.N_REQ(4), .SEL_W(2), .DATA_W(1)) bus ();

    mux_rr_scheduler #(
        .N_REQ    (4),
        .SEL_W    (2),
        .DATA_W   (1),
        .MAX_HOLD (MAXH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       dout;
        logic       valid;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    int   m_ptr;
    int   m_owner;
    int   m_cnt;
    obs_t m;

    function automatic int pick(logic [3:0] r, int from, int excl);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (from + k) % 4;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    function void model_reset();
        m_ptr   = 0;
        m_owner = -1;
        m_cnt   = 0;
        m       = '0;
        exp_q.delete();
    endfunction

    function void model_step(logic [3:0] r, logic [3:0] d);
        int   w;
        obs_t n;
        n       = m;
        n.valid = (m.grant != 4'b0);
        if (m.grant != 4'b0) n.dout = d[m.sel];
        w = -1;
        if (m_owner < 0) begin
            w = pick(r, m_ptr, -1);
        end else if (!r[m_owner]) begin
            w = pick(r, m_ptr, -1);
            if (w < 0) m_owner = -1;
        end
`ifdef HOLD_LIMIT_EN
        else if (m_cnt == MAXH - 1) begin
            w = pick(r, m_ptr, m_owner);
        end else begin
            m_cnt++;
        end
`endif
        if (w >= 0) begin
            m_owner = w;
            m_ptr   = (w + 1) % 4;
            m_cnt   = 0;
        end
        n.grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        n.busy  = (m_owner >= 0);
        if (m_owner >= 0) n.sel = 2'(m_owner);
        m = n;
        exp_q.push_back(n);
    endfunction

    // Drive one cycle of stimulus at a negedge, compare after the posedge.
    task automatic step(input logic [3:0] r, input logic [3:0] d, input string tag);
        obs_t e, o;
        bus.req     = r;
        bus.data_in = d;
        model_step(r, d);
        @(posedge clk);
        #1;
        o.grant = bus.grant;
        o.sel   = bus.sel;
        o.busy  = bus.busy;
        o.dout  = bus.data_out[0];
        o.valid = bus.valid_out;
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL %s: got grant=%b sel=%0d busy=%b data_out=%b valid_out=%b, want grant=%b sel=%0d busy=%b data_out=%b valid_out=%b",
                     tag, o.grant, o.sel, o.busy, o.dout, o.valid,
                     e.grant, e.sel, e.busy, e.dout, e.valid);
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        bus.req     = 4'b0;
        bus.data_in = 4'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.req     = 4'b1111;
        bus.data_in = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.grant !== 4'b0 || bus.sel !== 2'd0) begin
            failures++;
            $display("FAIL reset_grant: got grant=%b sel=%0d, want 0000 0", bus.grant, bus.sel);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.valid_out !== 1'b0 || bus.data_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got busy=%b valid_out=%b data_out=%b, want 0 0 0",
                     bus.busy, bus.valid_out, bus.data_out);
        end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        step(4'b1111, 4'b0000, "reset_release");
        checks++;
        if (bus.grant !== 4'b0001 || bus.sel !== 2'd0) begin
            failures++;
            $display("FAIL reset_first_grant: got grant=%b sel=%0d, want 0001 0", bus.grant, bus.sel);
        end
    endtask

    task automatic test_single();
        apply_reset();
        step(4'b0100, 4'b0100, "single_grant");
        checks++;
        if (bus.grant !== 4'b0100 || bus.sel !== 2'd2) begin
            failures++;
            $display("FAIL single_grant_val: got grant=%b sel=%0d, want 0100 2", bus.grant, bus.sel);
        end
        step(4'b0100, 4'b0100, "single_data");
        checks++;
        if (bus.data_out !== 1'b1 || bus.valid_out !== 1'b1) begin
            failures++;
            $display("FAIL single_data_val: got data_out=%b valid_out=%b, want 1 1", bus.data_out, bus.valid_out);
        end
        step(4'b0000, 4'b0100, "single_drop");
        checks++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_drop_val: got grant=%b busy=%b, want 0000 0", bus.grant, bus.busy);
        end
        step(4'b0000, 4'b0000, "single_idle");
        checks++;
        if (bus.valid_out !== 1'b0 || bus.data_out !== 1'b1) begin
            failures++;
            $display("FAIL single_hold_data: got valid_out=%b data_out=%b, want 0 1", bus.valid_out, bus.data_out);
        end
    endtask

    task automatic test_round_robin();
        int         held;
        int         last;
        int         order[$];
        int         exp_ord[5];
        logic [3:0] r;
        logic       idle_seen;
        exp_ord   = '{0, 1, 2, 3, 0};
        held      = 0;
        last      = -1;
        idle_seen = 1'b0;
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            r = 4'b1111;
            if (m_owner >= 0 && held >= 2) r[m_owner] = 1'b0;
            step(r, 4'($urandom_range(0, 15)), "rr_cycle");
            if (bus.busy !== 1'b1) idle_seen = 1'b1;
            if (m_owner != last) begin
                int gi;
                gi = -1;
                for (int b = 0; b < 4; b++) if (bus.grant[b]) gi = b;
                order.push_back(gi);
                last = m_owner;
                held = 1;
            end else begin
                held++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            int got;
            got = (i < order.size()) ? order[i] : -1;
            checks++;
            if (got != exp_ord[i]) begin
                failures++;
                $display("FAIL rr_order[%0d]: got owner %0d, want %0d", i, got, exp_ord[i]);
            end
        end
        checks++;
        if (idle_seen) begin
            failures++;
            $display("FAIL rr_no_bubble: got busy low during rotation, want busy held high");
        end
    endtask

    task automatic test_wrap_skip();
        apply_reset();
        step(4'b0100, 4'b0000, "wrap_first");
        step(4'b0000, 4'b0000, "wrap_release");
        step(4'b0011, 4'b0001, "wrap_to0");
        checks++;
        if (bus.grant !== 4'b0001 || bus.sel !== 2'd0) begin
            failures++;
            $display("FAIL wrap_to0_val: got grant=%b sel=%0d, want 0001 0", bus.grant, bus.sel);
        end
        step(4'b0010, 4'b0010, "wrap_to1");
        checks++;
        if (bus.grant !== 4'b0010 || bus.sel !== 2'd1) begin
            failures++;
            $display("FAIL wrap_to1_val: got grant=%b sel=%0d, want 0010 1", bus.grant, bus.sel);
        end
    endtask

    task automatic test_hold();
        logic [3:0] exp_g;
        apply_reset();
        for (int s = 1; s <= 18; s++) begin
            step(4'b0011, 4'($urandom_range(0, 15)), "hold_cycle");
            if (s == 8 || s == 9 || s == 16 || s == 17) begin
`ifdef HOLD_LIMIT_EN
                exp_g = (s == 9 || s == 16) ? 4'b0010 : 4'b0001;
`else
                exp_g = 4'b0001;
`endif
                checks++;
                if (bus.grant !== exp_g) begin
                    failures++;
                    $display("FAIL hold_step%0d: got grant=%b, want %b", s, bus.grant, exp_g);
                end
            end
        end
        // Lone owner past the limit, then a competitor appears.
        apply_reset();
        for (int s = 0; s < 12; s++) step(4'b0001, 4'b0001, "hold_sat");
        step(4'b0011, 4'b0000, "hold_sat_rotate");
`ifdef HOLD_LIMIT_EN
        exp_g = 4'b0010;
`else
        exp_g = 4'b0001;
`endif
        checks++;
        if (bus.grant !== exp_g) begin
            failures++;
            $display("FAIL hold_saturate: got grant=%b, want %b", bus.grant, exp_g);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(4'b0010, 4'b0010, "ar_grant");
        step(4'b0010, 4'b0010, "ar_data");
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.grant !== 4'b0 || bus.sel !== 2'd0 || bus.busy !== 1'b0 ||
            bus.data_out !== 1'b0 || bus.valid_out !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got grant=%b sel=%0d busy=%b data_out=%b valid_out=%b, want all 0",
                     bus.grant, bus.sel, bus.busy, bus.data_out, bus.valid_out);
        end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        // ptr back at 0 picks requester 1 ahead of 2.
        step(4'b0110, 4'b0000, "ar_regrant");
        checks++;
        if (bus.grant !== 4'b0010) begin
            failures++;
            $display("FAIL async_ptr_restart: got grant=%b, want 0010", bus.grant);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.req     = 4'b0;
        bus.data_in = 4'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_skip();
        test_hold();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
- Round-robin scheduler that shares one N:1 selection mux (select-driven, `F`-style output) between N requesters.
- Arbitrates request lines and drives the binary mux select and a one-hot grant.
- Registers the selected data bit(s) and flags them valid.
- Sits directly in front of the lab mux datapath; it replaces the hand-driven select/input stimulus with a sequenced owner.

Parameters:
- N_REQ, 4, number of requesters (power of two, 2..16).
- SEL_W, 2, select width; must equal log2(N_REQ).
- DATA_W, 1, width of each requester's data lane.
- MAX_HOLD, 8, cycles a grant may be held before forced rotation (used only with HOLD_LIMIT_EN).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester request, level-sensitive.
- data_in  input  N_REQ*DATA_W  packed lanes; lane k = data_in[k*DATA_W +: DATA_W].
- grant  output  N_REQ  one-hot grant, registered.
- sel  output  SEL_W  binary index of the granted requester, registered.
- busy  output  1  high while any grant is active.
- data_out  output  DATA_W  registered mux output, lane[sel] sampled one cycle after grant.
- valid_out  output  1  data_out is valid for the current cycle.

Behaviour:
- Reset (async, rst_n=0):
  - grant=0, sel=0, busy=0, data_out=0, valid_out=0.
  - Priority pointer ptr=0; hold counter=0; FSM=IDLE.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any req bit is set, pick the first set bit searching from ptr upward, wrapping mod N_REQ.
  - Next edge: grant=onehot(w), sel=w, busy=1, FSM→GRANT, ptr=(w+1) mod N_REQ.
  - Latency from req to grant: 1 cycle.
- GRANT:
  - The owner keeps the grant while req[sel]=1.
  - When req[sel] drops, the same edge re-arbitrates from ptr:
    - If any other request is pending, grant moves directly (no idle bubble).
    - Otherwise grant=0, busy=0, FSM→IDLE.
- Datapath:
  - data_out <= lane[sel] every cycle grant≠0; valid_out <= (grant≠0).
  - data_out is one cycle behind grant; valid_out=0 keeps the last data_out.
- Boundary and simultaneous-event rules:
  - All N requesting simultaneously: grant order is ptr, ptr+1, … with wrap.
  - A requester deasserting on the same edge another asserts: the new requester is eligible in that arbitration.
  - Requester reasserting immediately after release: it waits its turn (ptr has advanced past it).
  - req for an index ≥ N_REQ does not exist; grant is always one-hot or zero.
  - Reset mid-grant returns to the reset values immediately (async), including ptr.

Optional Feature:
- Macro: HOLD_LIMIT_EN.
- Defined:
  - A hold counter increments each GRANT cycle.
  - At count MAX_HOLD-1, if any other req is set, the grant rotates to the next requester on the following edge, even if req[sel] is still high.
  - If no other requester is pending, the owner keeps the grant and the counter saturates.
  - The counter clears on every new grant.
- Not defined:
  - No counter is instantiated; the owner holds indefinitely while its req is high.

Decomposition:
- Shared package mux_sched_pkg:
  - localparams for default N_REQ/SEL_W/DATA_W.
  - typedef for FSM state enum {IDLE, GRANT}.
  - function onehot_to_bin.
- One sub-module: rr_pick (combinational rotating priority encoder).
  - Inputs: req, ptr. Outputs: found, idx.
  - Reused by later arbiters in the lab series.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 → grant=0, sel=0, busy=0, valid_out=0; release → next edge grant=4'b0001, sel=0.
- Single requester: req=4'b0100, data_in lane2=1 → grant=4'b0100 after 1 cycle, sel=2; data_out=1 and valid_out=1 one cycle later; drop req → grant=0, busy=0 next edge.
- Round robin: req=4'b1111 held, each owner drops req for one cycle after 2 cycles of grant → grant order 0,1,2,3,0 with no idle cycle between owners.
- Wrap and skip: ptr=3 (after grant to 2), req=4'b0011 → grant goes to 0, then 1.
- HOLD_LIMIT_EN with MAX_HOLD=8: req0 and req1 held high continuously → grant toggles 0→1→0 every 8 cycles. Without the macro, grant stays on 0 indefinitely.
- Async reset mid-grant: assert rst_n=0 between edges while grant=4'b0010 → all outputs 0 immediately; after release, req=4'b0010 → grant=4'b0010 (ptr restarted at 0).
